// File: rtl/game_seq_if.sv
// Board/datapath-side bundle of the flappy-bird game-flow controller.
// The master drives the requests (start, pause, level, hit) and reads the
// sequencing outputs; the controller itself attaches through the slave view.
interface game_seq_if;
  logic        start;
  logic        pause;
  logic [3:0]  Level;
  logic        hit;
  logic [2:0]  state;
  logic        move_tick;
  logic        sec_tick;
  logic        clear_field;
  logic        spawn;
  logic [2:0]  pipe_sel;
  logic [4:0]  Life;
  logic [15:0] score;
  logic        game_over;

  modport master (
    output start, pause, Level, hit,
    input  state, move_tick, sec_tick, clear_field, spawn, pipe_sel,
           Life, score, game_over
  );

  modport slave (
    input  start, pause, Level, hit,
    output state, move_tick, sec_tick, clear_field, spawn, pipe_sel,
           Life, score, game_over
  );
endinterface

// File: rtl/game_seq.sv
// Game-flow controller for the 8x8 LED flappy-bird datapath.
// Walks each round through IDLE -> READY countdown -> PLAY <-> HURT -> OVER,
// and produces the level-dependent move tick, the 1 s tick, pipe-spawn
// requests with an LFSR-chosen pipe type, the life thermometer and the BCD
// survival time. Tick and spawn pulses are decoded from registered counters
// gated by pause, so a pause freezes them within the same cycle.
module game_seq #(
  parameter int MV_DIV_L0    = 12500000,
  parameter int MV_DIV_L1    = 9000000,
  parameter int MV_DIV_L2    = 6000000,
  parameter int MV_DIV_L3    = 3000000,
  parameter int MV_DIV_L4    = 2500000,
  parameter int SEC_DIV      = 50000000,
  parameter int READY_SECS   = 3,
  parameter int INVULN_TICKS = 4,
  parameter int SPAWN_TICKS  = 9
) (
  input  logic      CLK,
  input  logic      RST_N,
  game_seq_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    PLAY  = 3'd2,
    HURT  = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Move counter is sized for the slowest level
  localparam int MV_M01 = (MV_DIV_L0 > MV_DIV_L1) ? MV_DIV_L0 : MV_DIV_L1;
  localparam int MV_M23 = (MV_DIV_L2 > MV_DIV_L3) ? MV_DIV_L2 : MV_DIV_L3;
  localparam int MV_M03 = (MV_M01 > MV_M23) ? MV_M01 : MV_M23;
  localparam int MV_MAX = (MV_M03 > MV_DIV_L4) ? MV_M03 : MV_DIV_L4;

  localparam int MV_W  = $clog2(MV_MAX + 1);
  localparam int SEC_W = $clog2(SEC_DIV + 1);
  localparam int RDY_W = $clog2(READY_SECS + 1);
  localparam int INV_W = $clog2(INVULN_TICKS + 1);
  localparam int SPN_W = $clog2(SPAWN_TICKS + 1);

  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_DIV - 1);
  localparam logic [RDY_W-1:0] RDY_LAST = RDY_W'(READY_SECS - 1);
  localparam logic [INV_W-1:0] INV_LAST = INV_W'(INVULN_TICKS - 1);
  localparam logic [SPN_W-1:0] SPN_LAST = SPN_W'(SPAWN_TICKS - 1);

  localparam logic [15:0] SCORE_MAX = 16'h9959;

  state_t             state_reg;
  logic [SEC_W-1:0]   sec_cnt_reg;
  logic [MV_W-1:0]    mv_cnt_reg;
  logic [MV_W-1:0]    mv_last;
  logic [RDY_W-1:0]   ready_cnt_reg;
  logic [INV_W-1:0]   inv_cnt_reg;
  logic [SPN_W-1:0]   spawn_cnt_reg;
  logic [7:0]         lfsr_reg;
  logic [7:0]         lfsr_next;
  logic [2:0]         pipe_sel_reg;
  logic [4:0]         life_reg;
  logic [15:0]        score_reg;
  logic [3:0]         lvl_q;
  logic               clear_field_reg;

  logic in_play;
  logic in_round;
  logic sec_run;
  logic mv_run;
  logic sec_tick_w;
  logic move_tick_w;
  logic spawn_w;

  // One-step BCD mm:ss increment, saturating at 99:59
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [3:0] m1, m2, s1, s2;
    {m1, m2, s1, s2} = s;
    if (s == SCORE_MAX) begin
      return s;
    end
    if (s2 != 4'd9) begin
      s2 = s2 + 4'd1;
    end else begin
      s2 = 4'd0;
      if (s1 != 4'd5) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        if (m2 != 4'd9) begin
          m2 = m2 + 4'd1;
        end else begin
          m2 = 4'd0;
          m1 = m1 + 4'd1;
        end
      end
    end
    return {m1, m2, s1, s2};
  endfunction

  // Terminal move count for the level latched at round start (invalid codes fall back to level 0)
  always_comb begin
    case (lvl_q)
      4'b0001: mv_last = MV_W'(MV_DIV_L1 - 1);
      4'b0010: mv_last = MV_W'(MV_DIV_L2 - 1);
      4'b0100: mv_last = MV_W'(MV_DIV_L3 - 1);
      4'b1000: mv_last = MV_W'(MV_DIV_L4 - 1);
      default: mv_last = MV_W'(MV_DIV_L0 - 1);
    endcase
  end

  assign in_play     = (state_reg == PLAY) || (state_reg == HURT);
  assign in_round    = in_play || (state_reg == READY);
  assign sec_run     = in_round && !bus.pause;
  assign mv_run      = in_play && !bus.pause;
  assign sec_tick_w  = sec_run && (sec_cnt_reg == SEC_LAST);
  assign move_tick_w = mv_run && (mv_cnt_reg == mv_last);
  assign spawn_w     = move_tick_w && (spawn_cnt_reg == '0);
  assign lfsr_next   = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

  assign bus.state       = state_reg;
  assign bus.move_tick   = move_tick_w;
  assign bus.sec_tick    = sec_tick_w;
  assign bus.spawn       = spawn_w;
  assign bus.clear_field = clear_field_reg;
  // The stepped LFSR value is visible alongside its spawn pulse, then held
  assign bus.pipe_sel    = spawn_w ? lfsr_next[2:0] : pipe_sel_reg;
  assign bus.Life        = life_reg;
  assign bus.score       = score_reg;
  assign bus.game_over   = (state_reg == OVER);

  // Round sequencer, prescalers, spawn/LFSR and score; state-case assignments override the generic counting above them
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_reg       <= IDLE;
      sec_cnt_reg     <= '0;
      mv_cnt_reg      <= '0;
      ready_cnt_reg   <= '0;
      inv_cnt_reg     <= '0;
      spawn_cnt_reg   <= '0;
      lfsr_reg        <= 8'hA5;
      pipe_sel_reg    <= 3'd0;
      life_reg        <= 5'b11111;
      score_reg       <= 16'h0000;
      lvl_q           <= 4'b0000;
      clear_field_reg <= 1'b0;
    end else begin
      clear_field_reg <= 1'b0;

      if (sec_run) begin
        sec_cnt_reg <= sec_tick_w ? '0 : sec_cnt_reg + 1'b1;
      end
      if (mv_run) begin
        mv_cnt_reg <= move_tick_w ? '0 : mv_cnt_reg + 1'b1;
      end
      if (move_tick_w) begin
        spawn_cnt_reg <= (spawn_cnt_reg == SPN_LAST) ? '0 : spawn_cnt_reg + 1'b1;
      end
      if (spawn_w) begin
        lfsr_reg     <= lfsr_next;
        pipe_sel_reg <= lfsr_next[2:0];
      end
      if (sec_tick_w && in_play) begin
        score_reg <= bcd_inc(score_reg);
      end

      case (state_reg)
        IDLE, OVER: begin
          if (bus.start) begin
            state_reg       <= READY;
            clear_field_reg <= 1'b1;
            life_reg        <= 5'b11111;
            score_reg       <= 16'h0000;
            lvl_q           <= bus.Level;
            sec_cnt_reg     <= '0;
            mv_cnt_reg      <= '0;
            ready_cnt_reg   <= '0;
            inv_cnt_reg     <= '0;
            spawn_cnt_reg   <= '0;
          end
        end
        READY: begin
          if (sec_tick_w) begin
            if (ready_cnt_reg == RDY_LAST) begin
              state_reg     <= PLAY;
              ready_cnt_reg <= '0;
              mv_cnt_reg    <= '0;
              spawn_cnt_reg <= '0;
            end else begin
              ready_cnt_reg <= ready_cnt_reg + 1'b1;
            end
          end
        end
        PLAY: begin
          if (bus.hit && !bus.pause) begin
            life_reg    <= {life_reg[3:0], 1'b0};
            inv_cnt_reg <= '0;
            state_reg   <= (life_reg[3:0] == 4'b0000) ? OVER : HURT;
          end
        end
        HURT: begin
          if (move_tick_w) begin
            if (inv_cnt_reg == INV_LAST) begin
              state_reg   <= PLAY;
              inv_cnt_reg <= '0;
            end else begin
              inv_cnt_reg <= inv_cnt_reg + 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_seq.sv
// Self-checking bench for game_seq with short dividers.
// Expected pipe types and scores are queued when the matching stimulus or
// tick occurs and popped when the controller produces the result.
module tb_game_seq;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  always #5 CLK = ~CLK;

  game_seq_if bus_if();

  game_seq #(
    .MV_DIV_L0(4), .MV_DIV_L1(3), .MV_DIV_L2(5), .MV_DIV_L3(6), .MV_DIV_L4(2),
    .SEC_DIV(10), .READY_SECS(2), .INVULN_TICKS(2), .SPAWN_TICKS(3)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0]  exp_pipe[$];
  logic [15:0] exp_score[$];

  // Seconds survived -> BCD mm:ss, saturating at 99:59
  function automatic logic [15:0] secs_to_bcd(input int secs);
    int t, m, s;
    t = (secs > 5999) ? 5999 : secs;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic test_reset;
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    n_cmp++; if (bus_if.state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", bus_if.state); end
    n_cmp++; if (bus_if.Life !== 5'b11111) begin n_bad++; $display("FAIL reset_life: got %b want 11111", bus_if.Life); end
    n_cmp++; if (bus_if.score !== 16'h0000) begin n_bad++; $display("FAIL reset_score: got %h want 0000", bus_if.score); end
    n_cmp++; if (bus_if.pipe_sel !== 3'd0) begin n_bad++; $display("FAIL reset_pipe_sel: got %0d want 0", bus_if.pipe_sel); end
    n_cmp++; if ({bus_if.move_tick, bus_if.sec_tick, bus_if.spawn, bus_if.clear_field} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_pulses: got %b want 0000", {bus_if.move_tick, bus_if.sec_tick, bus_if.spawn, bus_if.clear_field});
    end
    n_cmp++; if (bus_if.game_over !== 1'b0) begin n_bad++; $display("FAIL reset_game_over: got %b want 0", bus_if.game_over); end
    RST_N = 1'b1;
    @(negedge CLK);
    $display("reset: state=%0d Life=%b score=%h", bus_if.state, bus_if.Life, bus_if.score);
  endtask

  task automatic test_start_ready;
    int cnt;
    int mt;
    int last;
    logic exp_sp;
    logic [2:0] e;
    // LFSR from A5: A5 -> 4A -> 95 -> 2A, pipe types are the low three bits
    exp_pipe.push_back(3'd2);
    exp_pipe.push_back(3'd5);
    exp_pipe.push_back(3'd2);
    bus_if.Level = 4'b0000;
    bus_if.start = 1'b1;
    @(negedge CLK);
    bus_if.start = 1'b0;
    n_cmp++; if (bus_if.clear_field !== 1'b1) begin n_bad++; $display("FAIL start_clear: got %b want 1", bus_if.clear_field); end
    cnt = 0;
    while (bus_if.state == 3'd1 && cnt < 40) begin
      if (cnt == 1) begin
        n_cmp++; if (bus_if.clear_field !== 1'b0) begin n_bad++; $display("FAIL clear_one_cycle: got %b want 0", bus_if.clear_field); end
      end
      cnt++;
      @(negedge CLK);
    end
    n_cmp++; if (cnt != 20) begin n_bad++; $display("FAIL ready_len: got %0d cycles want 20", cnt); end
    n_cmp++; if (bus_if.state !== 3'd2) begin n_bad++; $display("FAIL enter_play: got %0d want 2", bus_if.state); end
    $display("ready: %0d cycles in READY", cnt);
    mt = 0;
    last = -1;
    for (int i = 0; i < 36; i++) begin
      if (bus_if.move_tick === 1'b1) begin
        mt++;
        if (mt == 1) begin
          n_cmp++; if (i != 3) begin n_bad++; $display("FAIL first_move: got cycle %0d want 3", i); end
        end else begin
          n_cmp++; if (i - last != 4) begin n_bad++; $display("FAIL move_period: got %0d want 4", i - last); end
        end
        last = i;
        exp_sp = (((mt - 1) % 3) == 0);
        n_cmp++; if (bus_if.spawn !== exp_sp) begin n_bad++; $display("FAIL spawn_slot: tick %0d got %b want %b", mt, bus_if.spawn, exp_sp); end
        if (bus_if.spawn === 1'b1) begin
          n_cmp++;
          if (exp_pipe.size() == 0) begin
            n_bad++; $display("FAIL pipe_sel_extra: got %0d want no spawn", bus_if.pipe_sel);
          end else begin
            e = exp_pipe.pop_front();
            if (bus_if.pipe_sel !== e) begin n_bad++; $display("FAIL pipe_sel: got %0d want %0d", bus_if.pipe_sel, e); end
          end
          $display("spawn: move_tick %0d pipe_sel=%0d", mt, bus_if.pipe_sel);
        end
      end else begin
        n_cmp++; if (bus_if.spawn !== 1'b0) begin n_bad++; $display("FAIL spawn_without_move: got %b want 0", bus_if.spawn); end
      end
      @(negedge CLK);
    end
    n_cmp++; if (mt != 9) begin n_bad++; $display("FAIL move_count: got %0d want 9", mt); end
    n_cmp++; if (exp_pipe.size() != 0) begin n_bad++; $display("FAIL spawn_missing: got %0d left want 0", exp_pipe.size()); end
    n_cmp++; if (bus_if.score !== 16'h0003) begin n_bad++; $display("FAIL early_score: got %h want 0003", bus_if.score); end
  endtask

  task automatic test_hurt;
    int mt;
    int cyc;
    bus_if.hit = 1'b1;
    bus_if.start = 1'b1;
    @(negedge CLK);
    n_cmp++; if (bus_if.Life !== 5'b11110) begin n_bad++; $display("FAIL hurt_life: got %b want 11110", bus_if.Life); end
    n_cmp++; if (bus_if.state !== 3'd3) begin n_bad++; $display("FAIL hurt_state: got %0d want 3", bus_if.state); end
    mt = 0;
    cyc = 0;
    while (mt < 2 && cyc < 30) begin
      n_cmp++; if (bus_if.state !== 3'd3 || bus_if.clear_field !== 1'b0) begin
        n_bad++; $display("FAIL hurt_hold: got state %0d clear %b want 3/0", bus_if.state, bus_if.clear_field);
      end
      if (bus_if.move_tick === 1'b1) mt++;
      cyc++;
      @(negedge CLK);
    end
    bus_if.hit = 1'b0;
    bus_if.start = 1'b0;
    n_cmp++; if (mt != 2) begin n_bad++; $display("FAIL invuln_ticks: got %0d want 2", mt); end
    n_cmp++; if (bus_if.state !== 3'd2) begin n_bad++; $display("FAIL hurt_exit: got %0d want 2", bus_if.state); end
    n_cmp++; if (bus_if.Life !== 5'b11110) begin n_bad++; $display("FAIL hurt_ignore_hit: got %b want 11110", bus_if.Life); end
    $display("hurt: left after %0d cycles, Life=%b", cyc, bus_if.Life);
  endtask

  task automatic test_game_over;
    logic [4:0] lives [4];
    logic [2:0] want_st;
    int cyc;
    int bad;
    lives[0] = 5'b11100; lives[1] = 5'b11000; lives[2] = 5'b10000; lives[3] = 5'b00000;
    for (int k = 0; k < 4; k++) begin
      bus_if.hit = 1'b1;
      @(negedge CLK);
      bus_if.hit = 1'b0;
      want_st = (k == 3) ? 3'd4 : 3'd3;
      n_cmp++; if (bus_if.Life !== lives[k]) begin n_bad++; $display("FAIL hit_life: hit %0d got %b want %b", k, bus_if.Life, lives[k]); end
      n_cmp++; if (bus_if.state !== want_st) begin n_bad++; $display("FAIL hit_state: hit %0d got %0d want %0d", k, bus_if.state, want_st); end
      $display("hit: Life=%b state=%0d", bus_if.Life, bus_if.state);
      if (k < 3) begin
        cyc = 0;
        while (bus_if.state !== 3'd2 && cyc < 40) begin cyc++; @(negedge CLK); end
        n_cmp++; if (bus_if.state !== 3'd2) begin n_bad++; $display("FAIL recover_play: got %0d want 2", bus_if.state); end
      end
    end
    n_cmp++; if (bus_if.game_over !== 1'b1) begin n_bad++; $display("FAIL game_over: got %b want 1", bus_if.game_over); end
    bad = 0;
    repeat (100) begin
      if (bus_if.move_tick !== 1'b0 || bus_if.sec_tick !== 1'b0 || bus_if.spawn !== 1'b0 || bus_if.state !== 3'd4) bad++;
      @(negedge CLK);
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL over_quiet: got %0d active cycles want 0", bad); end
    n_cmp++; if (bus_if.Life !== 5'b00000) begin n_bad++; $display("FAIL over_life: got %b want 00000", bus_if.Life); end
    bus_if.start = 1'b1;
    @(negedge CLK);
    bus_if.start = 1'b0;
    n_cmp++; if (bus_if.state !== 3'd1) begin n_bad++; $display("FAIL restart_state: got %0d want 1", bus_if.state); end
    n_cmp++; if (bus_if.Life !== 5'b11111) begin n_bad++; $display("FAIL restart_life: got %b want 11111", bus_if.Life); end
    n_cmp++; if (bus_if.score !== 16'h0000) begin n_bad++; $display("FAIL restart_score: got %h want 0000", bus_if.score); end
    n_cmp++; if (bus_if.clear_field !== 1'b1 || bus_if.game_over !== 1'b0) begin
      n_bad++; $display("FAIL restart_flags: got clear %b over %b want 1/0", bus_if.clear_field, bus_if.game_over);
    end
    $display("restart: state=%0d Life=%b", bus_if.state, bus_if.Life);
  endtask

  task automatic test_score;
    int cyc;
    int secs;
    logic seen;
    logic [15:0] e;
    cyc = 0;
    while (bus_if.state !== 3'd2 && cyc < 40) begin cyc++; @(negedge CLK); end
    n_cmp++; if (bus_if.state !== 3'd2) begin n_bad++; $display("FAIL score_play: got %0d want 2", bus_if.state); end
    secs = 0;
    seen = 1'b0;
    cyc = 0;
    while (secs < 6002 && cyc < 61000) begin
      if (exp_score.size() != 0) begin
        e = exp_score.pop_front();
        n_cmp++; if (bus_if.score !== e) begin n_bad++; $display("FAIL score: after %0d s got %h want %h", secs, bus_if.score, e); end
        if (secs == 600 && !seen) begin
          seen = 1'b1;
          n_cmp++; if (bus_if.score !== 16'h1000) begin n_bad++; $display("FAIL score_carry: got %h want 1000", bus_if.score); end
        end
        if (secs % 600 == 0) $display("score: %0d s -> %h", secs, bus_if.score);
      end
      if (bus_if.sec_tick === 1'b1) begin
        secs++;
        exp_score.push_back(secs_to_bcd(secs));
      end
      cyc++;
      @(negedge CLK);
    end
    if (exp_score.size() != 0) begin
      e = exp_score.pop_front();
      n_cmp++; if (bus_if.score !== e) begin n_bad++; $display("FAIL score_last: got %h want %h", bus_if.score, e); end
    end
    n_cmp++; if (secs != 6002) begin n_bad++; $display("FAIL score_budget: got %0d s want 6002", secs); end
    n_cmp++; if (bus_if.score !== 16'h9959) begin n_bad++; $display("FAIL score_saturate: got %h want 9959", bus_if.score); end
    $display("score: saturated at %h", bus_if.score);
  endtask

  task automatic test_pause;
    int cyc;
    int bad;
    int first;
    cyc = 0;
    while (bus_if.move_tick !== 1'b1 && cyc < 10) begin cyc++; @(negedge CLK); end
    n_cmp++; if (bus_if.move_tick !== 1'b1) begin n_bad++; $display("FAIL pause_align: got %b want 1", bus_if.move_tick); end
    // Move count is 1 two cycles after a tick; pause holds it there
    repeat (2) @(negedge CLK);
    bus_if.pause = 1'b1;
    bad = 0;
    for (int i = 0; i < 37; i++) begin
      if (i == 10) bus_if.hit = 1'b1;
      if (bus_if.move_tick !== 1'b0 || bus_if.sec_tick !== 1'b0 || bus_if.spawn !== 1'b0 || bus_if.state !== 3'd2) bad++;
      @(negedge CLK);
    end
    bus_if.pause = 1'b0;
    bus_if.hit = 1'b0;
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL pause_quiet: got %0d active cycles want 0", bad); end
    n_cmp++; if (bus_if.Life !== 5'b11111) begin n_bad++; $display("FAIL pause_hit: got %b want 11111", bus_if.Life); end
    first = -1;
    for (int i = 0; i < 10; i++) begin
      if (bus_if.move_tick === 1'b1 && first < 0) first = i;
      @(negedge CLK);
    end
    n_cmp++; if (first != 2) begin n_bad++; $display("FAIL pause_resume: got tick at %0d want 2", first); end
    $display("pause: resumed, first move_tick %0d cycles after release", first);
  endtask

  task automatic test_level;
    int per;
    int cyc;
    int ticks;
    int last;
    int want_ticks;
    for (int c = 0; c < 2; c++) begin
      per = (c == 0) ? 3 : 4;
      want_ticks = (c == 0) ? 4 : 3;
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      bus_if.Level = (c == 0) ? 4'b0001 : 4'b0011;
      bus_if.start = 1'b1;
      @(negedge CLK);
      bus_if.start = 1'b0;
      if (c == 0) bus_if.Level = 4'b1000;
      cyc = 0;
      while (bus_if.state !== 3'd2 && cyc < 40) begin cyc++; @(negedge CLK); end
      n_cmp++; if (bus_if.state !== 3'd2) begin n_bad++; $display("FAIL level_play: got %0d want 2", bus_if.state); end
      ticks = 0;
      last = -1;
      for (int i = 0; i < 14; i++) begin
        if (bus_if.move_tick === 1'b1) begin
          n_cmp++;
          if (last < 0) begin
            if (i != per - 1) begin n_bad++; $display("FAIL level_first: got %0d want %0d", i, per - 1); end
          end else if (i - last != per) begin
            n_bad++; $display("FAIL level_period: got %0d want %0d", i - last, per);
          end
          last = i;
          ticks++;
        end
        @(negedge CLK);
      end
      n_cmp++; if (ticks != want_ticks) begin n_bad++; $display("FAIL level_ticks: got %0d want %0d", ticks, want_ticks); end
      $display("level: cfg %0d move period %0d, %0d ticks", c, per, ticks);
    end
  endtask

  task automatic test_reset_in_hurt;
    bus_if.hit = 1'b1;
    @(negedge CLK);
    bus_if.hit = 1'b0;
    n_cmp++; if (bus_if.state !== 3'd3) begin n_bad++; $display("FAIL pre_reset_hurt: got %0d want 3", bus_if.state); end
    RST_N = 1'b0;
    @(negedge CLK);
    n_cmp++; if (bus_if.state !== 3'd0) begin n_bad++; $display("FAIL mid_reset_state: got %0d want 0", bus_if.state); end
    n_cmp++; if (bus_if.Life !== 5'b11111) begin n_bad++; $display("FAIL mid_reset_life: got %b want 11111", bus_if.Life); end
    n_cmp++; if (bus_if.score !== 16'h0000) begin n_bad++; $display("FAIL mid_reset_score: got %h want 0000", bus_if.score); end
    n_cmp++; if (bus_if.pipe_sel !== 3'd0) begin n_bad++; $display("FAIL mid_reset_pipe_sel: got %0d want 0", bus_if.pipe_sel); end
    n_cmp++; if ({bus_if.move_tick, bus_if.sec_tick, bus_if.spawn, bus_if.clear_field, bus_if.game_over} !== 5'b00000) begin
      n_bad++; $display("FAIL mid_reset_pulses: got %b want 00000",
                        {bus_if.move_tick, bus_if.sec_tick, bus_if.spawn, bus_if.clear_field, bus_if.game_over});
    end
    RST_N = 1'b1;
    @(negedge CLK);
    $display("mid-round reset: state=%0d Life=%b", bus_if.state, bus_if.Life);
  endtask

  initial begin
    bus_if.start = 1'b0;
    bus_if.pause = 1'b0;
    bus_if.hit   = 1'b0;
    bus_if.Level = 4'b0000;
    test_reset;
    test_start_ready;
    test_hurt;
    test_game_over;
    test_score;
    test_pause;
    test_level;
    test_reset_in_hurt;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
